// File: rtl/tdc_pkg.sv
// Shared types and default widths for the TDC hit generator and readout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

  localparam int TDC_DATA_W = 21;
  localparam int DEF_DLY_W  = 16;
  localparam int DEF_WID_W  = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    HIGH,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/tdc_timebase.sv
// Free-running coarse timebase, wraps modulo 2^TS_W.
// Latency: reads 0 in the first cycle after rst is released.
// Backpressure: none, never stalls.
module tdc_timebase
  import tdc_pkg::*;
#(
  parameter int TS_W = TDC_DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  output logic [TS_W-1:0] count
);

  // Increment every cycle; natural overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count + TS_W'(1);
  end

endmodule

// File: rtl/tdc_hit_generator.sv
// Turns a programmed delay/width/period/count schedule into registered hit pulses with timebase stamps.
// Latency: first hit edge cfg_delay+1 cycles after accept; done one cycle after the last high cycle.
// Backpressure: cfg_ready only in IDLE; cfg_valid while busy is dropped, nothing is queued.
module tdc_hit_generator
  import tdc_pkg::*;
#(
  parameter int TS_W  = TDC_DATA_W,
  parameter int DLY_W = DEF_DLY_W,
  parameter int WID_W = DEF_WID_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [WID_W-1:0] cfg_width,
  input  logic [DLY_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             abort,
  output logic             hit,
  output logic             busy,
  output logic             done,
  output logic             stamp_valid,
  output logic [TS_W-1:0]  stamp,
  output logic [CNT_W-1:0] hit_idx
);

  state_t           state, state_nxt;
  logic             accept, start_pulse;
  logic [TS_W-1:0]  tb_now;
  logic [WID_W-1:0] w_eff, wid_m1, wid_cnt;
  logic [DLY_W:0]   w_ext, p_min, p_req, p_eff;
  logic [DLY_W-1:0] gap_m1, gap_len_m1, dly_cnt, gap_cnt;
  logic [CNT_W-1:0] pul_cnt;

  tdc_timebase #(.TS_W(TS_W)) u_timebase (
    .clk   (clk),
    .rst   (rst),
    .count (tb_now)
  );

  assign accept = cfg_valid && cfg_ready;

  // Effective geometry: width of at least one cycle, period at least one cycle longer
  // than the width so consecutive pulses never merge. Only sampled on accept.
  always_comb begin
    w_eff  = (cfg_width == '0) ? WID_W'(1) : cfg_width;
    w_ext  = (DLY_W+1)'(w_eff);
    p_min  = w_ext + (DLY_W+1)'(1);
    p_req  = (DLY_W+1)'(cfg_period);
    p_eff  = (p_req > p_min) ? p_req : p_min;
    gap_m1 = DLY_W'(p_eff - w_ext - (DLY_W+1)'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: abort wins in DELAY/HIGH/GAP; counters expire at zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cfg_count == '0)      state_nxt = DONE;
          else if (cfg_delay == '0) state_nxt = HIGH;
          else                      state_nxt = DELAY;
        end
      end
      DELAY: begin
        if (abort)               state_nxt = DONE;
        else if (dly_cnt == '0)  state_nxt = HIGH;
      end
      HIGH: begin
        if (abort)               state_nxt = DONE;
        else if (wid_cnt == '0)  state_nxt = (pul_cnt == '0) ? DONE : GAP;
      end
      GAP: begin
        if (abort)               state_nxt = DONE;
        else if (gap_cnt == '0)  state_nxt = HIGH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start_pulse = (state_nxt == HIGH) && (state != HIGH);

  // Registered outputs and down-counters, all loaded on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b1;
      stamp_valid <= 1'b0;
      stamp       <= '0;
      hit_idx     <= '0;
      dly_cnt     <= '0;
      wid_cnt     <= '0;
      wid_m1      <= '0;
      gap_cnt     <= '0;
      gap_len_m1  <= '0;
      pul_cnt     <= '0;
    end else begin
      hit         <= (state_nxt == HIGH);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      cfg_ready   <= (state_nxt == IDLE);
      stamp_valid <= start_pulse;

      if (accept) begin
        dly_cnt    <= cfg_delay - DLY_W'(1);
        wid_m1     <= w_eff - WID_W'(1);
        gap_len_m1 <= gap_m1;
        pul_cnt    <= cfg_count - CNT_W'(1);
      end else if (state == DELAY) begin
        dly_cnt <= dly_cnt - DLY_W'(1);
      end

      // The stamp is the timebase value of the cycle hit goes high, i.e. one past now.
      if (start_pulse) begin
        wid_cnt <= accept ? (w_eff - WID_W'(1)) : wid_m1;
        stamp   <= tb_now + TS_W'(1);
        hit_idx <= (state == GAP) ? (hit_idx + CNT_W'(1)) : '0;
      end else if (state == HIGH) begin
        wid_cnt <= wid_cnt - WID_W'(1);
      end

      if ((state == HIGH) && (state_nxt == GAP)) begin
        gap_cnt <= gap_len_m1;
        pul_cnt <= pul_cnt - CNT_W'(1);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - DLY_W'(1);
      end
    end
  end

endmodule

// File: doc/tdc_hit_generator.md
Name: tdc_hit_generator

Overview:
- Digital-to-time counterpart of the tapped-delay TDC: converts a programmed digital schedule into `hit` pulses on clock-cycle boundaries.
- Drives the TDC hit input on the test/calibration path.
- Reports the timebase value at every emitted rising edge, so TDC codes can be checked against a known coarse time.
- Fully synchronous, one clock domain.

Parameters:
- TS_W, 21, width of free-running timebase and stamp (matches TDC out_data width)
- DLY_W, 16, width of cfg_delay and cfg_period
- WID_W, 8, width of cfg_width
- CNT_W, 8, width of cfg_count and hit_idx

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  high only in IDLE
- cfg_delay  in  DLY_W  cycles from accept to first rising edge
- cfg_width  in  WID_W  high time per pulse, in cycles
- cfg_period  in  DLY_W  rising-to-rising spacing, in cycles
- cfg_count  in  CNT_W  number of pulses in the burst
- abort  in  1  terminate the burst
- hit  out  1  generated pulse, registered
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle burst-complete strobe
- stamp_valid  out  1  one-cycle strobe on each rising edge of hit
- stamp  out  TS_W  timebase value in the cycle hit first goes high
- hit_idx  out  CNT_W  index of the pulse being stamped, 0-based

Behaviour:
- Reset values: hit=0, busy=0, done=0, stamp_valid=0, stamp=0, hit_idx=0, cfg_ready=1, timebase=0, state=IDLE.
- Timebase:
  - Free-running, increments every cycle, wraps modulo 2^TS_W.
  - Reads 0 in the first cycle after rst deasserts.
- Handshake:
  - A config is accepted when cfg_valid && cfg_ready; all cfg_* fields are latched on that edge.
  - cfg_valid while not ready is ignored; nothing is queued.
- Effective values:
  - W = max(cfg_width, 1).
  - P = max(cfg_period, W+1).
- States: IDLE -> DELAY -> HIGH -> GAP -> HIGH ... -> DONE -> IDLE.
- Timing, with the accept cycle as N:
  - Pulse k (k = 0..cfg_count-1) is high in cycles N+1+cfg_delay+k*P through N+cfg_delay+k*P+W.
  - cfg_delay=0 gives hit high in cycle N+1.
  - hit is low in all other cycles.
- stamp_valid, stamp and hit_idx update in the first high cycle of each pulse:
  - stamp = timebase in that cycle.
  - hit_idx = k.
  - stamp and hit_idx hold their values between strobes.
- End of burst:
  - The cycle after the last pulse's final high cycle is DONE: hit=0, done=1, busy=1.
  - The next cycle is IDLE with cfg_ready=1.
- cfg_count=0: DELAY is skipped, DONE occurs in cycle N+1, and no pulses are emitted.
- abort in any non-IDLE state other than DONE:
  - Next cycle is DONE: hit=0, done=1, no further stamps.
  - abort takes priority over all other transitions.
  - abort in IDLE or DONE is ignored.
- rst mid-burst: all outputs return to their reset values on the next edge; no done strobe.
- Timebase wrap during a burst: pulse spacing is unaffected; stamps wrap modulo 2^TS_W.
- Down-counters load on transitions: delay counter, width counter, gap counter (P-W), pulse counter. There are no combinational paths from inputs to hit.

Decomposition:
- Package tdc_pkg holds:
  - the state enum (IDLE, DELAY, HIGH, GAP, DONE);
  - TDC_DATA_W=21;
  - default widths.
- Natural sub-module: tdc_timebase, a free-running TS_W counter with synchronous reset, reused later by the TDC readout.

Test Plan:
- Reset release, accept at timebase=10 with delay=3, width=2, period=5, count=3:
  - hit high at timebase 14-15, 19-20 and 24-25.
  - stamps 14/19/24 with hit_idx 0/1/2.
  - done at 26; cfg_ready at 27.
- delay=0, width=0, period=0, count=2, accepted at timebase 40 (W=1, P=2):
  - hit high at 41 and 43.
  - done at 44.
- count=0, accepted at timebase 5:
  - no hit and no stamp_valid.
  - done at 6; cfg_ready at 7.
- Burst as in test 1; abort asserted at timebase 20, during the second pulse:
  - hit low at 21, done at 21.
  - no stamp at 24; cfg_ready at 22.
- cfg_valid held high during a burst with different values: ignored; the next accept occurs only in the first IDLE cycle after done.
- TS_W=8 with the burst accepted at timebase 250, delay=2, width=1, period=4, count=3:
  - stamps 253, 1, 5.
  - done at 6.
